// File: rtl/vc_switch_allocator_pkg.sv
// rtl/vc_switch_allocator_pkg.sv - flit type encodings, FSM states and type helpers shared by the NoC input port
package vc_switch_allocator_pkg;

   localparam logic [1:0] FLIT_BODY      = 2'b00;
   localparam logic [1:0] FLIT_HEAD      = 2'b01;
   localparam logic [1:0] FLIT_TAIL      = 2'b10;
   localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic logic is_head(input logic [1:0] ftype);
      return (ftype == FLIT_HEAD) || (ftype == FLIT_HEAD_TAIL);
   endfunction

   function automatic logic is_tail(input logic [1:0] ftype);
      return (ftype == FLIT_TAIL) || (ftype == FLIT_HEAD_TAIL);
   endfunction

endpackage

// File: rtl/vc_switch_allocator_rr_arbiter.sv
// rtl/vc_switch_allocator_rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr_i
// Kept generic so the output-port allocator can reuse it.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [ID_W-1:0] gnt_id_o,
   output logic            gnt_vld_o
);

   logic            found;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 0; k < N; k++) begin
         idx = ID_W'((int'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx;
         end
      end
   end

   assign gnt_vld_o = |req_i;

endmodule

// File: rtl/vc_switch_allocator.sv
// rtl/vc_switch_allocator.sv - wormhole switch allocator sharing one output port between N_VC virtual channels
// Grant is locked to one VC from header arbitration until its tail flit transfers.
module vc_switch_allocator
   import vc_switch_allocator_pkg::*;
#(
   parameter int N_VC    = 4,
   parameter int VC_ID_W = 2,
   parameter int DATA_W  = 10
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [N_VC*DATA_W-1:0]   flit_i,
   input  logic [N_VC-1:0]          flit_vld_i,
   input  logic                     out_rdy_i,
   output logic [N_VC-1:0]          chan_alloc_o,
   output logic [N_VC-1:0]          chan_rdy_o,
   output logic [DATA_W-1:0]        data_o,
   output logic                     data_vld_o,
   output logic [VC_ID_W-1:0]       grant_id_o,
   output logic                     busy_o,
   output logic                     err_o
);

   state_e               state_q, state_d;
   logic [N_VC-1:0]      grant_q, grant_d;
   logic [VC_ID_W-1:0]   grant_id_q, grant_id_d;
   logic [VC_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic                 first_q, first_d;
   logic                 err_q, err_d;

   logic [N_VC-1:0]      req;
   logic [N_VC-1:0]      arb_gnt;
   logic [VC_ID_W-1:0]   arb_id;
   logic                 arb_vld;
   logic [DATA_W-1:0]    sel_flit;
   logic [1:0]           sel_type;
   logic                 sel_vld;
   logic                 xfer;

   always_comb begin
      req = '0;
      for (int i = 0; i < N_VC; i++) begin
         req[i] = flit_vld_i[i] & is_head(flit_i[i*DATA_W + DATA_W - 2 +: 2]);
      end
   end

   rr_arbiter #(
      .N    (N_VC),
      .ID_W (VC_ID_W)
   ) u_rr_arbiter (
      .req_i     (req),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_id_o  (arb_id),
      .gnt_vld_o (arb_vld)
   );

   assign sel_flit = flit_i[int'(grant_id_q)*DATA_W +: DATA_W];
   assign sel_type = sel_flit[DATA_W-1 -: 2];
   assign sel_vld  = flit_vld_i[grant_id_q];

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      first_d    = first_q;
      err_d      = 1'b0;
      data_o     = '0;
      data_vld_o = 1'b0;
      chan_rdy_o = '0;
      xfer       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               state_d    = ST_BUSY;
               grant_d    = arb_gnt;
               grant_id_d = arb_id;
               rr_ptr_d   = (arb_id == VC_ID_W'(N_VC - 1)) ? '0 : arb_id + 1'b1;
               first_d    = 1'b1;
            end
         end
         ST_BUSY: begin
            data_o     = sel_flit;
            data_vld_o = sel_vld;
            chan_rdy_o = grant_q & {N_VC{out_rdy_i}};
            xfer       = sel_vld & out_rdy_i;
            if (xfer) begin
               first_d = 1'b0;
               // A header after the packet's first flit is a protocol error; the grant is still honoured.
               err_d   = is_head(sel_type) & ~first_q;
               if (is_tail(sel_type)) begin
                  state_d    = ST_IDLE;
                  grant_d    = '0;
                  grant_id_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         first_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         first_q    <= first_d;
         err_q      <= err_d;
      end
   end

   assign chan_alloc_o = grant_q;
   assign grant_id_o   = grant_id_q;
   assign busy_o       = (state_q == ST_BUSY);
   assign err_o        = err_q;

endmodule
